uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit; legal range 4 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5 to 9.
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port i_Clock, input, 1 bit: the single clock; all logic runs on its rising edge, with no derived clocks.
REQ-006 SHALL have port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line; idles high.
REQ-008 SHALL have port i_Rx_Ready, input, 1 bit: consumer accepts the held frame.
REQ-009 SHALL have port o_Rx_Valid, output, 1 bit: the holding register contains a frame.
REQ-010 SHALL have port o_Rx_Data, output, DATA_BITS bits: received data, LSB first on the line.
REQ-011 SHALL have ports o_Parity_Err, o_Frame_Err and o_Break, outputs, 1 bit each: per-frame flags, qualified by o_Rx_Valid.
REQ-012 SHALL have port o_Overrun, output, 1 bit: sticky flag indicating at least one frame was lost since the last acceptance.
REQ-013 SHALL have port o_Busy, output, 1 bit: high while the state machine is not in IDLE.

Function
REQ-014 SHALL pass i_Rx_Serial through a two-flop synchroniser before any use.
REQ-015 SHALL size the bit counter at $clog2(CLKS_PER_BIT) bits, and the counter SHALL never wrap past CLKS_PER_BIT-1.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-017 IDLE SHALL leave on a synchronised falling edge (previous sample 1, current sample 0); a line held low continuously does not start a frame.
REQ-018 START SHALL sample the line at count (CLKS_PER_BIT-1)/2 and go to DATA if the sample is 0; a sample of 1 is a false start, SHALL return to IDLE, and SHALL produce no output.
REQ-019 DATA SHALL sample every CLKS_PER_BIT cycles, shifting in DATA_BITS bits LSB first.
REQ-020 After DATA, the state machine SHALL go to PARITY when PARITY is not 0, and to STOP otherwise.
REQ-021 PARITY SHALL set the parity-error flag when (XOR of the data bits and the parity bit) is 1 in even mode, or 0 in odd mode.
REQ-022 STOP SHALL sample each of the STOP_BITS stop bits at mid-bit, and any sample of 0 SHALL set the frame-error flag.
REQ-023 The frame SHALL complete at the mid-bit sample of the last stop bit, and the state machine SHALL return to IDLE the next cycle without waiting for the bit end.
REQ-024 A break SHALL be flagged when all data bits, the parity bit (if present) and the first stop bit sample 0; the frame SHALL complete with o_Break=1 and o_Frame_Err=1, then wait in BREAK_WAIT until the line samples 1.
REQ-025 o_Rx_Valid SHALL rise on the clock edge after the completing sample.
REQ-026 On frame completion with o_Rx_Valid=0, or with i_Rx_Ready=1 in the same cycle, the block SHALL load the data and flags, set o_Rx_Valid=1 and clear o_Overrun.
REQ-027 On frame completion with o_Rx_Valid=1 and i_Rx_Ready=0, the block SHALL discard the new frame, keep the held data and set o_Overrun.
REQ-028 When i_Rx_Ready=1 and o_Rx_Valid=1 with no frame completing, o_Rx_Valid SHALL clear on the next edge, and o_Overrun SHALL clear with it.
REQ-029 o_Rx_Data and the per-frame flags SHALL be stable while o_Rx_Valid=1.

Reset
REQ-030 Asserting i_Reset SHALL set the state to IDLE, clear the counters and all outputs to 0, and set the synchroniser flops and the previous-sample register to 1.
REQ-031 Reset mid-frame SHALL abort the frame, and no o_Rx_Valid SHALL result from the partial frame.
REQ-032 After reset release, a line stuck low SHALL not start a frame until a 1 is first sampled.

Structure
REQ-033 A shared package uart_pkg SHALL hold the state encoding and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-034 The synchroniser and edge detector SHALL be a single sub-module, uart_rx_sync, with the same clock and reset.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-035 Bench SHALL cover: PARITY=0, send 0xA5 -> one o_Rx_Valid with o_Rx_Data=0xA5 and all flags 0.
REQ-036 Bench SHALL cover: PARITY=1, send 0x03 with parity bit 1 -> o_Parity_Err=1 and data 0x03; with parity bit 0 -> o_Parity_Err=0.
REQ-037 Bench SHALL cover: a 6-cycle low glitch in IDLE -> no o_Rx_Valid and the state back in IDLE; then a valid 0x55 -> data 0x55.
REQ-038 Bench SHALL cover: i_Rx_Ready=0 and two frames 0x11 then 0x22 -> o_Rx_Data=0x11 and o_Overrun=1; then a one-cycle i_Rx_Ready pulse -> o_Rx_Valid=0 and o_Overrun=0.
REQ-039 Bench SHALL cover: the line held low for 20 bit times -> o_Break=1, o_Frame_Err=1, data 0x00, and no further frame until the line returns high.
REQ-040 Bench SHALL cover: DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x3C with the second stop bit 0 -> o_Frame_Err=1 and data 0x3C; also i_Reset asserted mid-DATA -> no o_Rx_Valid and all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM state encoding, parity modes and a parity check helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Data is zero-extended to 9 bits, so the padding does not affect the XOR.
    function automatic logic parity_error(input logic [8:0] data, input logic par_bit, input int mode);
        logic x;
        x = (^data) ^ par_bit;
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser plus falling-edge detector for the serial line; 2-cycle latency to o_Rx_Bit.
// No backpressure: samples every clock. Edges are ignored until the prev flop holds a real line sample.
module uart_rx_sync (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Rx_Serial,
    output logic o_Rx_Bit,
    output logic o_Fall
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fill_q <= 2'd0;
        end else begin
            meta_q <= i_Rx_Serial;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    // A line stuck low through reset must not look like a 1->0 edge from the reset values.
    assign o_Rx_Bit = sync_q;
    assign o_Fall   = (fill_q == 2'd3) && prev_q && !sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with one-deep holding register; o_Rx_Valid rises one edge after the last stop sample.
// Holding register uses valid/ready; a frame completing while full and not accepted is dropped and sets o_Overrun.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Ready,
    output logic                 o_Rx_Valid,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Overrun,
    output logic                 o_Busy
);
    import uart_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic rx_bit;
    logic rx_fall;

    uart_rx_sync u_sync (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Rx_Bit    (rx_bit),
        .o_Fall      (rx_fall)
    );

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 zero_q;
    logic                 par_err_q;
    logic                 frm_err_q;

    logic                 valid_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_out_q;
    logic                 ferr_out_q;
    logic                 brk_out_q;
    logic                 ovr_q;

    logic cnt_last;
    logic stop_smp;
    logic brk_d;
    logic frm_err_d;
    logic done_d;

    always_comb begin
        cnt_last  = (cnt_q == CNT_LAST);
        stop_smp  = (state_q == ST_STOP) && cnt_last;
        // Break is decided on the first stop bit, even when a second one is configured.
        brk_d     = stop_smp && !stop_idx_q && zero_q && !rx_bit;
        frm_err_d = frm_err_q | (stop_smp & ~rx_bit);
        done_d    = stop_smp && (brk_d || (stop_idx_q == STOP_LAST));
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            zero_q     <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rx_fall) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q      <= '0;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        zero_q     <= 1'b1;
                        par_err_q  <= 1'b0;
                        frm_err_q  <= 1'b0;
                        state_q    <= rx_bit ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_last) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_bit, shift_q[DATA_BITS-1:1]};
                        zero_q    <= zero_q & ~rx_bit;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_last) begin
                        cnt_q     <= '0;
                        par_err_q <= parity_error(9'(shift_q), rx_bit, PARITY);
                        zero_q    <= zero_q & ~rx_bit;
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_last) begin
                        cnt_q      <= '0;
                        frm_err_q  <= frm_err_d;
                        stop_idx_q <= 1'b1;
                        if (done_d) begin
                            state_q <= brk_d ? ST_BREAK_WAIT : ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rx_bit) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (done_d) begin
                if (!valid_q || i_Rx_Ready) begin
                    data_q     <= shift_q;
                    perr_out_q <= par_err_q;
                    ferr_out_q <= frm_err_d;
                    brk_out_q  <= brk_d;
                    valid_q    <= 1'b1;
                    ovr_q      <= 1'b0;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && i_Rx_Ready) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
        end
    end

    assign o_Rx_Valid   = valid_q;
    assign o_Rx_Data    = data_q;
    assign o_Parity_Err = perr_out_q;
    assign o_Frame_Err  = ferr_out_q;
    assign o_Break      = brk_out_q;
    assign o_Overrun    = ovr_q;
    assign o_Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7O2) sharing one clock and reset.
module tb_uart_rx_param;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx;
    logic [2:0] rdy;
    logic [2:0] vld, perr, ferr, brk, ovr, busy;
    logic [7:0] dat0, dat1;
    logic [6:0] dat2;

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .i_Rx_Ready(rdy[0]),
        .o_Rx_Valid(vld[0]), .o_Rx_Data(dat0), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]),
        .o_Break(brk[0]), .o_Overrun(ovr[0]), .o_Busy(busy[0]));

    uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .i_Rx_Ready(rdy[1]),
        .o_Rx_Valid(vld[1]), .o_Rx_Data(dat1), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]),
        .o_Break(brk[1]), .o_Overrun(ovr[1]), .o_Busy(busy[1]));

    uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .i_Rx_Ready(rdy[2]),
        .o_Rx_Valid(vld[2]), .o_Rx_Data(dat2), .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]),
        .o_Break(brk[2]), .o_Overrun(ovr[2]), .o_Busy(busy[2]));

    // Rising edges of o_Rx_Valid per instance.
    logic [2:0] vld_prev = 3'b000;
    int vcnt0 = 0, vcnt1 = 0, vcnt2 = 0;
    always @(posedge clk) begin
        vld_prev <= vld;
        if (vld[0] && !vld_prev[0]) vcnt0 <= vcnt0 + 1;
        if (vld[1] && !vld_prev[1]) vcnt1 <= vcnt1 + 1;
        if (vld[2] && !vld_prev[2]) vcnt2 <= vcnt2 + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] dat_of(input int sel);
        case (sel)
            0:       return {1'b0, dat0};
            1:       return {1'b0, dat1};
            default: return {2'b00, dat2};
        endcase
    endfunction

    task automatic check_out(input int sel, input string tag, input logic [8:0] ed,
                             input logic ev, input logic ep, input logic ef,
                             input logic eb, input logic eo);
        @(negedge clk);
        check({tag, "_vld"},  vld[sel],    ev);
        check({tag, "_data"}, dat_of(sel), ed);
        check({tag, "_perr"}, perr[sel],   ep);
        check({tag, "_ferr"}, ferr[sel],   ef);
        check({tag, "_brk"},  brk[sel],    eb);
        check({tag, "_ovr"},  ovr[sel],    eo);
    endtask

    // bits[0] is the start bit; each bit is held for one full bit time.
    task automatic send(input int sel, input logic [15:0] bits, input int nbits);
        @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            rx[sel] = bits[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx[sel] = 1'b1;
    endtask

    task automatic hold_low(input int sel, input int cycles);
        @(posedge clk); #1;
        rx[sel] = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rdy(input int sel);
        @(posedge clk); #1;
        rdy[sel] = 1'b1;
        @(posedge clk); #1;
        rdy[sel] = 1'b0;
    endtask

    initial begin
        rx  = 3'b111;
        rdy = 3'b000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int s = 0; s < 3; s++) check_out(s, "reset", 9'h0, 0, 0, 0, 0, 0);
        check("reset_busy", busy, 3'b000);
        repeat (5) @(posedge clk);

        // 8N1 0xA5
        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
        check_out(0, "a5", 9'hA5, 1, 0, 0, 0, 0);
        check("a5_count", vcnt0, 1);
        pulse_rdy(0);
        @(negedge clk);
        check("a5_ack_vld", vld[0], 0);

        // 8E1 0x03: parity bit 1 is wrong, parity bit 0 is right
        send(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
        check_out(1, "par_bad", 9'h03, 1, 1, 0, 0, 0);
        pulse_rdy(1);
        send(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
        check_out(1, "par_ok", 9'h03, 1, 0, 0, 0, 0);
        check("par_count", vcnt1, 2);
        pulse_rdy(1);

        // 6-cycle glitch is a false start
        hold_low(0, 6);
        rx[0] = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_busy", busy[0], 0);
        check("glitch_vld", vld[0], 0);
        check("glitch_count", vcnt0, 1);
        send(0, 16'({1'b1, 8'h55, 1'b0}), 10);
        check_out(0, "x55", 9'h55, 1, 0, 0, 0, 0);
        pulse_rdy(0);

        // Two frames with no acceptance: first kept, overrun set
        send(0, 16'({1'b1, 8'h11, 1'b0}), 10);
        send(0, 16'({1'b1, 8'h22, 1'b0}), 10);
        check_out(0, "ovr", 9'h11, 1, 0, 0, 0, 1);
        check("ovr_count", vcnt0, 3);
        pulse_rdy(0);
        @(negedge clk);
        check("ovr_ack_vld", vld[0], 0);
        check("ovr_ack_ovr", ovr[0], 0);

        // Break: line low for 20 bit times
        hold_low(0, 20 * BIT);
        check_out(0, "brk", 9'h00, 1, 0, 1, 1, 0);
        check("brk_busy", busy[0], 1);
        pulse_rdy(0);
        repeat (4 * BIT) @(posedge clk);
        @(negedge clk);
        check("brk_hold_vld", vld[0], 0);
        check("brk_hold_count", vcnt0, 4);
        rx[0] = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("brk_release_busy", busy[0], 0);
        send(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
        check_out(0, "after_brk", 9'h5A, 1, 0, 0, 0, 0);
        pulse_rdy(0);

        // 7O2 0x3C, odd parity bit 1, second stop bit 0
        send(2, 16'({1'b0, 1'b1, 1'b1, 7'h3C, 1'b0}), 11);
        check_out(2, "stop2", 9'h3C, 1, 0, 1, 0, 0);
        check("stop2_count", vcnt2, 1);
        pulse_rdy(2);

        // Reset in the middle of the data bits, line then stuck low
        @(posedge clk); #1;
        rx[2] = 1'b0;
        repeat (BIT) @(posedge clk);
        #1 rx[2] = 1'b0;
        repeat (BIT) @(posedge clk);
        #1 rx[2] = 1'b0;
        repeat (BIT) @(posedge clk);
        #1 rx[2] = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy[2], 1);
        rx[2] = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_out(2, "mid_rst", 9'h0, 0, 0, 0, 0, 0);
        check("mid_rst_busy", busy[2], 0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("stuck_low_busy", busy[2], 0);
        rx[2] = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("mid_rst_vld", vld[2], 0);
        check("mid_rst_count", vcnt2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
